// File: rtl/spio_hss_multiplexer_frame_rx_if.sv
// Link-side bundle for the spiNNlink frame receiver: received gtp words in,
// data flits out toward the frame disassembler.
interface spio_hss_multiplexer_frame_rx_if;
  logic [31:0] hsl_data;
  logic [3:0]  hsl_kchr;
  logic        hsl_vld;
  logic [31:0] frm_data;
  logic        frm_vld;
  logic        frm_last;
  logic        frm_good;

  modport master (
    output hsl_data, hsl_kchr, hsl_vld,
    input  frm_data, frm_vld, frm_last, frm_good
  );

  modport slave (
    input  hsl_data, hsl_kchr, hsl_vld,
    output frm_data, frm_vld, frm_last, frm_good
  );
endinterface

// File: rtl/spio_hss_multiplexer_frame_rx.sv
// spiNNlink receive path: classifies gtp words, checks CRC and framing, forwards
// data flits and delivers ack/nak, ooc and remote cfc state to the sender.
module spio_hss_multiplexer_frame_rx #(
  parameter int unsigned MAX_FRM_WORDS = 9,
  parameter int unsigned SYNC_IDLES    = 4,
  parameter int unsigned ERR_LIMIT     = 8,
  parameter logic [7:0]  K_IDLE        = 8'hBC,
  parameter logic [7:0]  K_ACK         = 8'hFB,
  parameter logic [7:0]  K_NAK         = 8'hFD,
  parameter logic [7:0]  K_OOC         = 8'hF7,
  parameter logic [7:0]  K_CFC         = 8'hFE
) (
  input  logic        clk,
  input  logic        rst_n,
  spio_hss_multiplexer_frame_rx_if.slave lnk,
  output logic        ack_vld,
  output logic        ack_type,
  output logic [2:0]  ack_colour,
  output logic [4:0]  ack_seq,
  output logic        ooc_vld,
  output logic [2:0]  ooc_colour,
  output logic [7:0]  cfc_rem,
  output logic        rx_sync,
  output logic        reg_rfrm,
  output logic        reg_crce,
  output logic        reg_frme,
  output logic [23:0] reg_idsi
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] CHFR = 2'd1;
  localparam logic [1:0] DFRM = 2'd2;

  logic [1:0]  state_q;
  logic [7:0]  idle_cnt_q;
  logic [7:0]  err_cnt_q;
  logic [7:0]  wcnt_q;
  logic [15:0] crc_q;

  // CRC-16-CCITT, poly 0x1021, MSB first, no reflection or final xor
  function automatic logic [15:0] crc16w(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 16; i++) begin
      fb = r[15] ^ d[15 - i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc32w(input logic [15:0] c, input logic [31:0] d);
    return crc16w(crc16w(c, d[31:16]), d[15:0]);
  endfunction

  logic [7:0] code;
  logic [7:0] pay;
  logic       is_k;
  logic       is_d;
  logic       is_idle;
  logic       is_ctl;
  logic       ctl_crc_ok;
  logic       trm_crc_ok;
  logic       crc_err;
  logic       frm_err;

  always_comb begin
    code       = lnk.hsl_data[31:24];
    pay        = lnk.hsl_data[23:16];
    is_k       = (lnk.hsl_kchr == 4'b1000);
    is_d       = (lnk.hsl_kchr == 4'b0000);
    is_idle    = is_k && (code == K_IDLE);
    is_ctl     = is_k && ((code == K_ACK) || (code == K_NAK) ||
                          (code == K_OOC) || (code == K_CFC));
    ctl_crc_ok = (crc16w(16'hFFFF, lnk.hsl_data[31:16]) == lnk.hsl_data[15:0]);
    trm_crc_ok = (crc16w(crc_q, lnk.hsl_data[31:16]) == lnk.hsl_data[15:0]);
  end

  // Error classification of the current word, used for both pulses and the error counter
  always_comb begin
    crc_err = 1'b0;
    frm_err = 1'b0;
    if (lnk.hsl_vld) begin
      case (state_q)
        CHFR: begin
          if (is_ctl) crc_err = !ctl_crc_ok;
          else if (!is_d && !is_idle) frm_err = 1'b1;
        end
        DFRM: begin
          if (is_k && (code == K_CFC)) crc_err = !trm_crc_ok;
          else if (!is_d || (wcnt_q == 8'(MAX_FRM_WORDS))) frm_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      idle_cnt_q   <= '0;
      err_cnt_q    <= '0;
      wcnt_q       <= '0;
      crc_q        <= '0;
      lnk.frm_data <= '0;
      lnk.frm_vld  <= 1'b0;
      lnk.frm_last <= 1'b0;
      lnk.frm_good <= 1'b0;
      ack_vld      <= 1'b0;
      ack_type     <= 1'b0;
      ack_colour   <= '0;
      ack_seq      <= '0;
      ooc_vld      <= 1'b0;
      ooc_colour   <= '0;
      cfc_rem      <= '1;
      rx_sync      <= 1'b0;
      reg_rfrm     <= 1'b0;
      reg_crce     <= 1'b0;
      reg_frme     <= 1'b0;
      reg_idsi     <= '0;
    end else begin
      lnk.frm_data <= '0;
      lnk.frm_vld  <= 1'b0;
      lnk.frm_last <= 1'b0;
      lnk.frm_good <= 1'b0;
      ack_vld      <= 1'b0;
      ack_type     <= 1'b0;
      ack_colour   <= '0;
      ack_seq      <= '0;
      ooc_vld      <= 1'b0;
      ooc_colour   <= '0;
      reg_rfrm     <= 1'b0;
      reg_crce     <= 1'b0;
      reg_frme     <= 1'b0;

      if (lnk.hsl_vld) begin
        case (state_q)
          HUNT: begin
            if (is_idle) begin
              reg_idsi <= lnk.hsl_data[23:0];
              if (idle_cnt_q == 8'(SYNC_IDLES - 1)) begin
                rx_sync    <= 1'b1;
                state_q    <= CHFR;
                idle_cnt_q <= '0;
              end else begin
                idle_cnt_q <= idle_cnt_q + 8'd1;
              end
            end else begin
              idle_cnt_q <= '0;
            end
          end

          CHFR: begin
            if (is_d) begin
              lnk.frm_vld  <= 1'b1;
              lnk.frm_data <= lnk.hsl_data;
              crc_q        <= crc32w(16'hFFFF, lnk.hsl_data);
              wcnt_q       <= 8'd1;
              state_q      <= DFRM;
            end else if (is_idle) begin
              reg_idsi <= lnk.hsl_data[23:0];
            end else if (is_ctl) begin
              if (ctl_crc_ok) begin
                if ((code == K_ACK) || (code == K_NAK)) begin
                  ack_vld    <= 1'b1;
                  ack_type   <= (code == K_ACK);
                  ack_colour <= pay[7:5];
                  ack_seq    <= pay[4:0];
                end else if (code == K_OOC) begin
                  ooc_vld    <= 1'b1;
                  ooc_colour <= pay[7:5];
                end else begin
                  cfc_rem <= pay;
                end
              end else begin
                reg_crce <= 1'b1;
              end
            end else begin
              reg_frme <= 1'b1;
            end
          end

          DFRM: begin
            if (is_k && (code == K_CFC)) begin
              lnk.frm_vld  <= 1'b1;
              lnk.frm_last <= 1'b1;
              lnk.frm_good <= trm_crc_ok;
              if (trm_crc_ok) begin
                reg_rfrm <= 1'b1;
                cfc_rem  <= pay;
              end else begin
                reg_crce <= 1'b1;
              end
              state_q <= CHFR;
            end else if (frm_err) begin
              lnk.frm_vld  <= 1'b1;
              lnk.frm_last <= 1'b1;
              reg_frme     <= 1'b1;
              state_q      <= CHFR;
            end else begin
              lnk.frm_vld  <= 1'b1;
              lnk.frm_data <= lnk.hsl_data;
              crc_q        <= crc32w(crc_q, lnk.hsl_data);
              wcnt_q       <= wcnt_q + 8'd1;
            end
          end

          default: state_q <= HUNT;
        endcase

        // Placed after the case so losing sync overrides any transition chosen above;
        // every error in DFRM already closes the frame with frm_good = 0.
        if (crc_err || frm_err) begin
          if (err_cnt_q == 8'(ERR_LIMIT - 1)) begin
            rx_sync    <= 1'b0;
            state_q    <= HUNT;
            err_cnt_q  <= '0;
            idle_cnt_q <= '0;
          end else begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
        end else if (state_q != HUNT) begin
          err_cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// Directed bench for spio_hss_multiplexer_frame_rx with a word-level reference model
// compared against every registered output on each falling clock edge.
module tb_spio_hss_multiplexer_frame_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spio_hss_multiplexer_frame_rx_if lnk ();

  logic        ack_vld, ack_type, ooc_vld, rx_sync, reg_rfrm, reg_crce, reg_frme;
  logic [2:0]  ack_colour, ooc_colour;
  logic [4:0]  ack_seq;
  logic [7:0]  cfc_rem;
  logic [23:0] reg_idsi;

  spio_hss_multiplexer_frame_rx #(
    .MAX_FRM_WORDS (9),
    .SYNC_IDLES    (4),
    .ERR_LIMIT     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lnk        (lnk),
    .ack_vld    (ack_vld),
    .ack_type   (ack_type),
    .ack_colour (ack_colour),
    .ack_seq    (ack_seq),
    .ooc_vld    (ooc_vld),
    .ooc_colour (ooc_colour),
    .cfc_rem    (cfc_rem),
    .rx_sync    (rx_sync),
    .reg_rfrm   (reg_rfrm),
    .reg_crce   (reg_crce),
    .reg_frme   (reg_frme),
    .reg_idsi   (reg_idsi)
  );

  typedef struct packed {
    logic [31:0] frm_data;
    logic        frm_vld, frm_last, frm_good;
    logic        ack_vld, ack_type;
    logic [2:0]  ack_colour;
    logic [4:0]  ack_seq;
    logic        ooc_vld;
    logic [2:0]  ooc_colour;
    logic [7:0]  cfc_rem;
    logic        rx_sync, reg_rfrm, reg_crce, reg_frme;
    logic [23:0] reg_idsi;
  } outs_t;

  int    total = 0;
  int    bad = 0;
  bit    chk_en = 1'b0;
  outs_t nx, ex;

  // Model state: link synchronised, frame open, run lengths, and the open frame's words
  bit          m_sync, m_frame;
  int          m_idles, m_errs;
  logic [31:0] fq[$];

  function automatic outs_t rst_outs();
    outs_t o;
    o = '0;
    o.cfc_rem = 8'hFF;
    return o;
  endfunction

  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] ctl(input logic [7:0] code, input logic [7:0] pay, input bit flip);
    logic [15:0] c;
    c = crc8(crc8(16'hFFFF, code), pay);
    return {code, pay, c ^ {15'b0, flip}};
  endfunction

  function automatic logic [31:0] term(input logic [31:0] w[$], input logic [7:0] pay, input bit flip);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (w[i]) for (int b = 3; b >= 0; b--) c = crc8(c, w[i][8*b +: 8]);
    c = crc8(crc8(c, 8'hFE), pay);
    return {8'hFE, pay, c ^ {15'b0, flip}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_frame = 0; m_idles = 0; m_errs = 0;
    fq.delete();
    nx = rst_outs();
  endtask

  task automatic model_idle();
    nx.frm_data = '0; nx.frm_vld = 0; nx.frm_last = 0; nx.frm_good = 0;
    nx.ack_vld = 0; nx.ack_type = 0; nx.ack_colour = '0; nx.ack_seq = '0;
    nx.ooc_vld = 0; nx.ooc_colour = '0;
    nx.reg_rfrm = 0; nx.reg_crce = 0; nx.reg_frme = 0;
  endtask

  task automatic close_frame(input bit good);
    nx.frm_vld = 1; nx.frm_last = 1; nx.frm_good = good; nx.frm_data = '0;
    m_frame = 0;
    fq.delete();
  endtask

  task automatic model(input logic [3:0] k, input logic [31:0] d);
    bit kw, dw, err, ok;
    logic [7:0] code, pay;
    logic [15:0] c;
    kw = (k == 4'b1000); dw = (k == 4'b0000);
    code = d[31:24]; pay = d[23:16]; err = 0;
    if (!m_sync) begin
      if (kw && code == 8'hBC) begin
        nx.reg_idsi = d[23:0];
        m_idles++;
        if (m_idles == 4) begin m_sync = 1; m_idles = 0; nx.rx_sync = 1; end
      end else m_idles = 0;
      return;
    end
    if (!m_frame) begin
      if (dw) begin
        nx.frm_vld = 1; nx.frm_data = d; fq.push_back(d); m_frame = 1;
      end else if (kw && code == 8'hBC) begin
        nx.reg_idsi = d[23:0];
      end else if (kw && (code inside {8'hFB, 8'hFD, 8'hF7, 8'hFE})) begin
        if (crc8(crc8(16'hFFFF, code), pay) == d[15:0]) begin
          if (code == 8'hFB || code == 8'hFD) begin
            nx.ack_vld = 1; nx.ack_type = (code == 8'hFB);
            nx.ack_colour = pay[7:5]; nx.ack_seq = pay[4:0];
          end else if (code == 8'hF7) begin
            nx.ooc_vld = 1; nx.ooc_colour = pay[7:5];
          end else nx.cfc_rem = pay;
        end else begin nx.reg_crce = 1; err = 1; end
      end else begin nx.reg_frme = 1; err = 1; end
    end else begin
      if (dw && fq.size() < 9) begin
        nx.frm_vld = 1; nx.frm_data = d; fq.push_back(d);
      end else if (kw && code == 8'hFE) begin
        c = 16'hFFFF;
        foreach (fq[i]) for (int b = 3; b >= 0; b--) c = crc8(c, fq[i][8*b +: 8]);
        c = crc8(crc8(c, code), pay);
        ok = (c == d[15:0]);
        close_frame(ok);
        if (ok) begin nx.reg_rfrm = 1; nx.cfc_rem = pay; end
        else begin nx.reg_crce = 1; err = 1; end
      end else begin
        close_frame(0); nx.reg_frme = 1; err = 1;
      end
    end
    if (err) begin
      m_errs++;
      if (m_errs == 8) begin
        m_sync = 0; nx.rx_sync = 0; m_errs = 0; m_idles = 0;
        m_frame = 0; fq.delete();
      end
    end else m_errs = 0;
  endtask

  task automatic send(input logic [3:0] k, input logic [31:0] d);
    @(negedge clk);
    lnk.hsl_vld = 1'b1; lnk.hsl_kchr = k; lnk.hsl_data = d;
    model(k, d);
    @(posedge clk); #1;
    lnk.hsl_vld = 1'b0; lnk.hsl_kchr = '0; lnk.hsl_data = '0;
    model_idle();
  endtask

  task automatic send_d(input logic [31:0] d); send(4'b0000, d); endtask
  task automatic send_k(input logic [31:0] d); send(4'b1000, d); endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ex <= rst_outs();
    else        ex <= nx;

  always @(negedge clk) if (chk_en) begin
    chk("frm_data",   lnk.frm_data, ex.frm_data);
    chk("frm_vld",    {31'b0, lnk.frm_vld},  {31'b0, ex.frm_vld});
    chk("frm_last",   {31'b0, lnk.frm_last}, {31'b0, ex.frm_last});
    chk("frm_good",   {31'b0, lnk.frm_good}, {31'b0, ex.frm_good});
    chk("ack",        {22'b0, ack_vld, ack_type, ack_colour, ack_seq},
                      {22'b0, ex.ack_vld, ex.ack_type, ex.ack_colour, ex.ack_seq});
    chk("ooc",        {28'b0, ooc_vld, ooc_colour}, {28'b0, ex.ooc_vld, ex.ooc_colour});
    chk("cfc_rem",    {24'b0, cfc_rem}, {24'b0, ex.cfc_rem});
    chk("rx_sync",    {31'b0, rx_sync}, {31'b0, ex.rx_sync});
    chk("reg_pulses", {29'b0, reg_rfrm, reg_crce, reg_frme},
                      {29'b0, ex.reg_rfrm, ex.reg_crce, ex.reg_frme});
    chk("reg_idsi",   {8'b0, reg_idsi}, {8'b0, ex.reg_idsi});
  end

  logic [31:0] w2[$];
  logic [31:0] w9[$];
  logic [31:0] wg[$];
  logic [7:0]  ref_str[9];
  logic [15:0] c_ref;
  logic [31:0] idl;

  initial begin
    lnk.hsl_vld = 1'b0; lnk.hsl_kchr = '0; lnk.hsl_data = '0;
    model_reset();

    ref_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c_ref = 16'hFFFF;
    foreach (ref_str[i]) c_ref = crc8(c_ref, ref_str[i]);
    chk("crc_ref_check", {16'b0, c_ref}, 32'h29B1);

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_cfc", {24'b0, cfc_rem}, 32'hFF);
    chk("rst_sync", {31'b0, rx_sync}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // acquire sync
    idl = {8'hBC, 24'h00ABCD};
    repeat (3) send_k(idl);
    chk("sync_before_4th", {31'b0, rx_sync}, 32'h0);
    send_k(idl);
    chk("sync_after_4th", {31'b0, rx_sync}, 32'h1);
    chk("idsi", {8'b0, reg_idsi}, 32'h00ABCD);

    // good two-word frame
    w2 = '{32'h01020304, 32'h05060708};
    send_d(w2[0]);
    chk("flit0_data", lnk.frm_data, 32'h01020304);
    chk("flit0_last", {31'b0, lnk.frm_last}, 32'h0);
    send_d(w2[1]);
    send_k(term(w2, 8'h0F, 0));
    chk("term_last_good", {30'b0, lnk.frm_last, lnk.frm_good}, 32'h3);
    chk("term_rfrm", {31'b0, reg_rfrm}, 32'h1);
    chk("term_cfc", {24'b0, cfc_rem}, 32'h0F);

    // same frame, terminator CRC bit 0 flipped
    send_d(w2[0]); send_d(w2[1]);
    send_k(term(w2, 8'h3C, 1));
    chk("bad_term_good", {30'b0, lnk.frm_last, lnk.frm_good}, 32'h2);
    chk("bad_term_crce", {31'b0, reg_crce}, 32'h1);
    chk("bad_term_cfc", {24'b0, cfc_rem}, 32'h0F);

    // control words
    send_k(ctl(8'hFB, {3'd5, 5'd17}, 0));
    chk("ack_fields", {22'b0, ack_vld, ack_type, ack_colour, ack_seq}, {22'b0, 1'b1, 1'b1, 3'd5, 5'd17});
    send_k(ctl(8'hFD, {3'd5, 5'd17}, 1));
    chk("nak_bad", {30'b0, ack_vld, reg_crce}, 32'h1);
    send_k(ctl(8'hFD, {3'd2, 5'd3}, 0));
    send_k(ctl(8'hF7, {3'd6, 5'd0}, 0));
    chk("ooc", {28'b0, ooc_vld, ooc_colour}, 32'hE);
    send_k(ctl(8'hFE, 8'hA5, 0));
    chk("cfc_standalone", {24'b0, cfc_rem}, 32'hA5);
    send_k({8'hBC, 24'h123456});

    // overlong frame, then exactly-max frame, then idle mid-frame
    for (int i = 1; i <= 10; i++) send_d(32'h1000_0000 + 32'(i));
    chk("overlong_abort", {28'b0, lnk.frm_vld, lnk.frm_last, lnk.frm_good, reg_frme}, 32'hD);
    for (int i = 1; i <= 9; i++) begin
      w9.push_back(32'hA000_0000 ^ 32'(i * 7));
      send_d(w9[i-1]);
    end
    send_k(term(w9, 8'h55, 0));
    chk("max_frame_good", {29'b0, lnk.frm_last, lnk.frm_good, reg_rfrm}, 32'h7);
    send_d(32'hDEADBEEF); send_d(32'hCAFEF00D);
    send_k({8'hBC, 24'h000001});
    chk("idle_abort", {28'b0, lnk.frm_vld, lnk.frm_last, lnk.frm_good, reg_frme}, 32'hD);

    // unknown kchr and unknown code, then a gapped frame
    send(4'b0100, 32'h11223344);
    chk("bad_kchr", {31'b0, reg_frme}, 32'h1);
    send_k(ctl(8'h1C, 8'h00, 0));
    send_k({8'hBC, 24'h000002});
    wg = '{32'h0BADF00D, 32'h76543210};
    send_d(wg[0]);
    repeat (3) @(negedge clk);
    send_d(wg[1]);
    send_k(term(wg, 8'h81, 0));

    // error run drops sync; HUNT ignores data
    repeat (7) send_k(ctl(8'hFB, 8'h21, 1));
    chk("sync_after_7_err", {31'b0, rx_sync}, 32'h1);
    send_k(ctl(8'hFB, 8'h21, 1));
    chk("sync_after_8_err", {31'b0, rx_sync}, 32'h0);
    send_d(32'h01010101); send_d(32'h02020202);
    repeat (3) send_k({8'hBC, 24'h000777});
    send_d(32'h03030303);
    repeat (3) send_k({8'hBC, 24'h000888});
    chk("no_sync_broken_run", {31'b0, rx_sync}, 32'h0);
    send_k({8'hBC, 24'h000888});
    chk("resync", {31'b0, rx_sync}, 32'h1);

    // reset mid-frame
    send_d(32'h44444444); send_d(32'h55555555);
    @(posedge clk); #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_outs", {22'b0, lnk.frm_vld, lnk.frm_last, rx_sync, cfc_rem}, 32'h0FF);
    @(posedge clk); #2 rst_n = 1'b1;
    send_d(32'h66666666);
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
